// File: rtl/axis_apb_master.sv
// Bridges a byte-oriented AXIS command stream to a single APB initiator and
// returns a status/read-data response stream; one APB transfer at a time.
module axis_apb_master #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  saxis_data_i,
    input  logic        saxis_tvalid_i,
    output logic        saxis_tready_o,
    output logic [7:0]  maxis_data_o,
    output logic        maxis_tvalid_o,
    input  logic        maxis_tready_i,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] OpWrite   = 8'h57;
    localparam logic [7:0] OpRead    = 8'h52;
    localparam logic [7:0] StsOk     = 8'h00;
    localparam logic [7:0] StsSlvErr = 8'h01;
    localparam logic [7:0] StsTout   = 8'h02;
    localparam logic [7:0] StsBadOp  = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StSetup,
        StAccess,
        StResp
    } state_t;

    state_t          r_state;
    logic [1:0]      r_byte_cnt;
    logic            r_is_read;
    logic [TW-1:0]   r_tout_cnt;
    logic [31:0]     r_rdata;
    logic [2:0]      r_rsp_left;

    logic            w_rx_fire;
    logic            w_tx_fire;
    logic [TW-1:0]   w_tout_next;

    // Gated with rst_n so the port reads 0 while reset is held and 1 immediately after.
    assign saxis_tready_o = rst_n & ((r_state == StIdle) | (r_state == StAddr) |
                                     (r_state == StWdata));
    assign w_rx_fire   = saxis_tvalid_i & saxis_tready_o;
    assign w_tx_fire   = maxis_tvalid_o & maxis_tready_i;
    assign w_tout_next = r_tout_cnt + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_byte_cnt     <= 2'd0;
            r_is_read      <= 1'b0;
            r_tout_cnt     <= '0;
            r_rdata        <= 32'd0;
            r_rsp_left     <= 3'd0;
            maxis_data_o   <= 8'd0;
            maxis_tvalid_o <= 1'b0;
            paddr          <= 32'd0;
            psel           <= 1'b0;
            penable        <= 1'b0;
            pwrite         <= 1'b0;
            pwdata         <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= 2'd0;
                        if (saxis_data_i == OpWrite || saxis_data_i == OpRead) begin
                            r_is_read <= (saxis_data_i == OpRead);
                            pwrite    <= (saxis_data_i == OpWrite);
                            r_state   <= StAddr;
                        end else begin
                            maxis_data_o   <= StsBadOp;
                            maxis_tvalid_o <= 1'b1;
                            r_rsp_left     <= 3'd0;
                            r_state        <= StResp;
                        end
                    end
                end
                StAddr: begin
                    if (w_rx_fire) begin
                        // LSB first: each new byte lands on top and shifts down.
                        paddr      <= {saxis_data_i, paddr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_is_read) begin
                                psel       <= 1'b1;
                                r_tout_cnt <= '0;
                                r_state    <= StSetup;
                            end else begin
                                r_state <= StWdata;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (w_rx_fire) begin
                        pwdata     <= {saxis_data_i, pwdata[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            psel       <= 1'b1;
                            r_tout_cnt <= '0;
                            r_state    <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    r_state <= StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        maxis_data_o   <= pslverr ? StsSlvErr : StsOk;
                        maxis_tvalid_o <= 1'b1;
                        if (r_is_read && !pslverr) begin
                            r_rdata    <= prdata;
                            r_rsp_left <= 3'd4;
                        end else begin
                            r_rsp_left <= 3'd0;
                        end
                        r_state <= StResp;
                    end else begin
                        r_tout_cnt <= w_tout_next;
                        if (w_tout_next == TW'(TIMEOUT)) begin
                            psel           <= 1'b0;
                            penable        <= 1'b0;
                            maxis_data_o   <= StsTout;
                            maxis_tvalid_o <= 1'b1;
                            r_rsp_left     <= 3'd0;
                            r_state        <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (w_tx_fire) begin
                        if (r_rsp_left == 3'd0) begin
                            maxis_tvalid_o <= 1'b0;
                            r_state        <= StIdle;
                        end else begin
                            maxis_data_o <= r_rdata[7:0];
                            r_rdata      <= {8'd0, r_rdata[31:8]};
                            r_rsp_left   <= r_rsp_left - 3'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/axis_apb_master.md
AXIS_APB_MASTER -- requirements
Module: axis_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the maximum number of ACCESS cycles to wait for pready.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port saxis_data_i, input, 8 bits: command byte stream, fed from the UART receiver.
REQ-005 SHALL have port saxis_tvalid_i, input, 1 bit, and port saxis_tready_o, output, 1 bit: AXIS slave handshake.
REQ-006 SHALL have port maxis_data_o, output, 8 bits: response byte stream, fed to the UART transmitter.
REQ-007 SHALL have port maxis_tvalid_o, output, 1 bit, and port maxis_tready_i, input, 1 bit: AXIS master handshake.
REQ-008 SHALL have APB initiator ports paddr (output, 32), psel (output, 1), penable (output, 1), pwrite (output, 1) and pwdata (output, 32).
REQ-009 SHALL have APB initiator ports prdata (input, 32), pready (input, 1) and pslverr (input, 1).

Function
REQ-010 SHALL accept a byte only on a clk edge where saxis_tvalid_i and saxis_tready_o are both 1.
REQ-011 SHALL drive saxis_tready_o=1 only in states IDLE, ADDR and WDATA; it is 0 in every other state.
REQ-012 SHALL implement the frame format as follows:
- Write: 0x57, then 4 address bytes, then 4 data bytes.
- Read: 0x52, then 4 address bytes.
- All multi-byte fields are LSB first.
REQ-013 SHALL implement state transitions as follows:
- IDLE -> ADDR on opcode 0x57 or 0x52.
- IDLE -> RESP on any other opcode, with status 0xEE and no APB transfer.
REQ-014 SHALL count address bytes 0..3 in ADDR; after the 4th byte, go to WDATA for a write or to SETUP for a read.
REQ-015 SHALL count 4 data bytes in WDATA, then go to SETUP.
REQ-016 SHALL hold SETUP for exactly one cycle with psel=1, penable=0, and paddr, pwrite and pwdata valid; the next state is ACCESS.
REQ-017 SHALL drive psel=1, penable=1 in ACCESS, with paddr, pwrite and pwdata held stable until completion.
REQ-018 SHALL complete a transfer on the first ACCESS cycle with pready=1:
- For a read, capture prdata on that edge.
- Record status 0x01 if pslverr=1, otherwise 0x00.
- Go to RESP.
- psel and penable are 0 on the following cycle.
REQ-019 SHALL implement the timeout as follows:
- A counter, cleared on SETUP entry, increments on each ACCESS cycle with pready=0.
- When it reaches TIMEOUT, drop psel and penable, set status 0x02 and go to RESP.
- prdata is not captured on a timeout.
REQ-020 SHALL send the response in RESP as follows:
- Write or error: 1 byte, the status.
- Read with status 0x00: 5 bytes, status 0x00 then the 4 prdata bytes LSB first.
- Read with status 0x01 or 0x02: status byte only.
REQ-021 SHALL hold maxis_data_o and maxis_tvalid_o stable while maxis_tvalid_o=1 and maxis_tready_i=0.
REQ-022 SHALL advance a byte only on a clk edge where maxis_tvalid_o and maxis_tready_i are both 1; after the last byte, return to IDLE with maxis_tvalid_o=0.
REQ-023 SHALL apply the following latency, assuming pready=1 on the first ACCESS cycle and the downstream always ready:
- psel rises 1 cycle after the last command byte is accepted.
- maxis_tvalid_o rises 2 cycles after psel rises.
REQ-024 SHALL never have more than one APB transfer outstanding, and SHALL never drive penable=1 with psel=0.
REQ-025 SHALL tolerate saxis_tvalid_i gaps mid-frame: the byte counters hold and there is no timeout on the AXIS side.

Reset
REQ-026 SHALL, on rst_n=0 and asynchronously, set the following:
- State = IDLE; byte counters and timeout counter = 0.
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- saxis_tready_o=0, maxis_tvalid_o=0, maxis_data_o=0.
REQ-027 SHALL set saxis_tready_o=1 in the first cycle after rst_n deasserts.
REQ-028 SHALL, on reset mid-transfer, drop psel and penable immediately; a partial frame is discarded and no response is sent.

Verification
REQ-029 Write: send 57 08 00 00 00 02 00 00 00 -> one APB write with paddr=0x8, pwdata=0x2, then exactly one response byte 0x00.
REQ-030 Read: send 52 0C 00 00 00 with the slave returning prdata=0xA5B6C7D8 and pready=1 after 3 wait cycles -> penable is high for 4 cycles, then response 00 D8 C7 B6 A5.
REQ-031 Error and timeout:
- Write with pslverr=1 -> response 0x01.
- Read with pready held at 0 -> penable is high for exactly TIMEOUT=256 cycles, then response 0x02 only.
REQ-032 Bad opcode and backpressure:
- Opcode 0x41 -> response 0xEE and psel never asserted.
- maxis_tready_i=0 for 10 cycles during a read response -> byte stable and no bytes lost or duplicated.
REQ-033 Reset: assert rst_n=0 during ACCESS -> psel=0 within the same cycle; after release, a fresh write to 0x4 completes normally.
